// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer (mult, multu, div, divu into HI/LO), one bit per cycle.
// Optional MDU_EARLY_TERM_EN: multiplies leave ITER once the remaining multiplier bits are all zero.
module mdu_seq #(
`ifdef PRJ1_FPGA_IMPL
    parameter int DATA_WIDTH = 4
`else
    parameter int DATA_WIDTH = 32
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_div_zero
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0]  LAST    = CW'(W - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [W-1:0]   ONE_W   = W'(1);
    localparam logic [2*W-1:0] ONE_2W  = (2*W)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [1:0]       r_op;
    logic [W-1:0]     r_a_raw;
    logic [W-1:0]     r_b_raw;
    logic [W-1:0]     r_opnd;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic             r_div_zero;
`ifdef MDU_EARLY_TERM_EN
    logic [W-1:0]     r_mplier;
`endif

    logic             w_accept;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_div_by_zero;
    logic [W-1:0]     w_abs_a;
    logic [W-1:0]     w_abs_b;
    logic [W:0]       w_sum;
    logic [2*W-1:0]   w_mul_next;
    logic [W:0]       w_part;
    logic             w_ge;
    logic [W-1:0]     w_diff;
    logic [2*W-1:0]   w_div_next;
    logic             w_iter_last;
    logic [2*W-1:0]   w_prod;
    logic [2*W-1:0]   w_prod_fix;
    logic [W-1:0]     w_quot_fix;
    logic [W-1:0]     w_rem_fix;

    assign w_accept      = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_is_div      = r_op[1];
    assign w_is_signed   = r_op[0];
    assign w_div_by_zero = w_is_div && (r_b_raw == '0);

    assign w_abs_a = (w_is_signed && r_a_raw[W-1]) ? (~r_a_raw + ONE_W) : r_a_raw;
    assign w_abs_b = (w_is_signed && r_b_raw[W-1]) ? (~r_b_raw + ONE_W) : r_b_raw;

    // Multiply step: conditional add into the upper half, then shift {carry,acc} right.
    assign w_sum      = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[W-1:1]};

    // Restoring divide step: the bit shifted out of rem takes part in the trial subtract.
    assign w_part     = r_acc[2*W-1:W-1];
    assign w_ge       = (w_part >= {1'b0, r_opnd});
    assign w_diff     = w_part[W-1:0] - r_opnd;
    assign w_div_next = w_ge ? {w_diff, r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};

`ifdef MDU_EARLY_TERM_EN
    assign w_iter_last = (r_cnt == LAST) || (!w_is_div && ((r_mplier >> 1) == '0));
    assign w_prod      = r_acc >> (LAST - r_cnt);
`else
    assign w_iter_last = (r_cnt == LAST);
    assign w_prod      = r_acc;
`endif

    assign w_prod_fix = r_sign_q ? (~w_prod + ONE_2W) : w_prod;
    assign w_quot_fix = r_sign_q ? (~r_acc[W-1:0] + ONE_W) : r_acc[W-1:0];
    assign w_rem_fix  = r_sign_r ? (~r_acc[2*W-1:W] + ONE_W) : r_acc[2*W-1:W];

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_div_zero = r_div_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                o_busy = 1'b1;
                w_next = w_div_by_zero ? S_FIX : S_ITER;
            end
            S_ITER: begin
                o_busy = 1'b1;
                if (w_iter_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                o_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = i_start ? S_LOAD : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operands are captured with start; the counter holds on the last iteration so FIX knows k-1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op       <= '0;
            r_a_raw    <= '0;
            r_b_raw    <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
`ifdef MDU_EARLY_TERM_EN
            r_mplier   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_op    <= i_op;
                r_a_raw <= i_a;
                r_b_raw <= i_b;
            end
            case (r_state)
                S_LOAD: begin
                    r_sign_q <= w_is_signed && (r_a_raw[W-1] ^ r_b_raw[W-1]);
                    r_sign_r <= w_is_signed && r_a_raw[W-1];
                    r_cnt    <= '0;
                    r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                    r_acc    <= {{W{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
`ifdef MDU_EARLY_TERM_EN
                    r_mplier <= w_abs_b;
`endif
                end
                S_ITER: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= w_iter_last ? r_cnt : (r_cnt + CNT_ONE);
`ifdef MDU_EARLY_TERM_EN
                    r_mplier <= r_mplier >> 1;
`endif
                end
                S_FIX: begin
                    if (w_div_by_zero) begin
                        r_hi       <= r_a_raw;
                        r_lo       <= '1;
                        r_div_zero <= 1'b1;
                    end else if (w_is_div) begin
                        r_hi       <= w_rem_fix;
                        r_lo       <= w_quot_fix;
                        r_div_zero <= 1'b0;
                    end else begin
                        r_hi       <= w_prod_fix[2*W-1:W];
                        r_lo       <= w_prod_fix[W-1:0];
                        r_div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a scoreboard of reference results, compared when done pulses.
`timescale 1ns/1ps
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divZero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sbQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleCount  = 0;
    int   startCycle  = 0;
    logic [W-1:0] lastHi;
    logic [W-1:0] lastLo;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    mdu_seq #(.DATA_WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_div_zero (divZero)
    );

    // Reference model built on 64-bit native arithmetic, independent of the shift/add datapath.
    function automatic exp_t model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
        exp_t         e;
        longint       sa;
        longint       sb;
        logic [63:0]  p;
        logic [W-1:0] absB;
        int           k;
        sa    = longint'($signed(ma));
        sb    = longint'($signed(mb));
        e.dz  = 1'b0;
        e.lat = W + 3;
        e.hi  = '0;
        e.lo  = '0;
        case (mop)
            2'b00: begin
                p    = {32'b0, ma} * {32'b0, mb};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p    = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (mb == '0) begin
                    e.hi  = ma;
                    e.lo  = '1;
                    e.dz  = 1'b1;
                    e.lat = 3;
                end else if (mop == 2'b10) begin
                    e.lo = ma / mb;
                    e.hi = ma % mb;
                end else begin
                    p    = sa / sb;
                    e.lo = p[31:0];
                    p    = sa % sb;
                    e.hi = p[31:0];
                end
            end
        endcase
`ifdef MDU_EARLY_TERM_EN
        if (!mop[1]) begin
            absB = (mop[0] && mb[W-1]) ? (32'd0 - mb) : mb;
            k = 1;
            for (int i = 0; i < W; i++) begin
                if (absB[i]) k = i + 1;
            end
            e.lat = k + 3;
        end
`else
        absB = mb;
        k    = 0;
`endif
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    // Drives start for one edge (the start edge) and records the reference result.
    task automatic applyStimulus(input logic [1:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb);
        start = 1'b1;
        op    = sop;
        a     = sa;
        b     = sb;
        sbQ.push_back(model(sop, sa, sb));
        @(posedge clk);
        #1;
        startCycle = cycleCount;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, checking busy along the way, then compares against the scoreboard.
    task automatic checkOutput(input string tag);
        exp_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        e = sbQ.pop_front();
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else checkVal({tag, " busy"}, 32'(busy), 32'd1);
        end
        checkVal({tag, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            lat = cycleCount - startCycle + 1;
            checkVal({tag, " latency"}, lat, e.lat);
            checkVal({tag, " busy at done"}, 32'(busy), 32'd0);
            checkVal({tag, " hi"}, hi, e.hi);
            checkVal({tag, " lo"}, lo, e.lo);
            checkVal({tag, " div_zero"}, 32'(divZero), 32'(e.dz));
        end
        lastHi = e.hi;
        lastLo = e.lo;
    endtask

    initial begin
        exp_t dropped;
        bit   sawDone;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkVal("reset busy", 32'(busy), 32'd0);
        checkVal("reset done", 32'(done), 32'd0);
        checkVal("reset hi", hi, 32'd0);
        checkVal("reset lo", lo, 32'd0);
        checkVal("reset div_zero", 32'(divZero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu max");
        checkVal("multu max hi const", hi, 32'hFFFF_FFFE);
        checkVal("multu max lo const", lo, 32'h0000_0001);
        @(negedge clk);

        applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd5);
        checkOutput("mult -3*5");
        checkVal("mult -3*5 hi const", hi, 32'hFFFF_FFFF);
        checkVal("mult -3*5 lo const", lo, 32'hFFFF_FFF1);
        @(negedge clk);

        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2");
        checkVal("div -7/2 lo const", lo, 32'hFFFF_FFFD);
        checkVal("div -7/2 hi const", hi, 32'hFFFF_FFFF);
        @(negedge clk);

        applyStimulus(2'b10, 32'd100, 32'd7);
        checkOutput("divu 100/7");
        checkVal("divu 100/7 lo const", lo, 32'd14);
        checkVal("divu 100/7 hi const", hi, 32'd2);
        @(negedge clk);

        applyStimulus(2'b10, 32'd7, 32'd0);
        checkOutput("divu by zero");
        checkVal("divu by zero flag const", 32'(divZero), 32'd1);
        @(negedge clk);

        applyStimulus(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
        checkOutput("mult clears div_zero");
        checkVal("div_zero cleared const", 32'(divZero), 32'd0);
        repeat (3) @(negedge clk);
        checkVal("hold hi", hi, lastHi);
        checkVal("hold lo", lo, lastLo);
        checkVal("idle busy", 32'(busy), 32'd0);

        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div overflow");
        checkVal("div overflow lo const", lo, 32'h8000_0000);
        checkVal("div overflow hi const", hi, 32'd0);
        applyStimulus(2'b10, 32'd1000, 32'd33);
        checkVal("back-to-back busy", 32'(busy), 32'd1);
        checkOutput("back-to-back divu");
        @(negedge clk);

        applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h0000_F00D);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd7;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("start ignored while busy");
        @(negedge clk);
        checkVal("ignored start not queued", 32'(busy), 32'd0);

        @(negedge clk);
        applyStimulus(2'b00, 32'h0F0F_0F0F, 32'h0001_2345);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("abort busy", 32'(busy), 32'd0);
        checkVal("abort done", 32'(done), 32'd0);
        checkVal("abort hi", hi, 32'd0);
        checkVal("abort lo", lo, 32'd0);
        dropped = sbQ.pop_back();
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkVal("no done after abort", 32'(sawDone), 32'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(2'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd0 : $urandom);
            checkOutput("random op");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
